// File: rtl/srl_fifo_pkg.sv
// Shared definitions for the shift-register FIFO controller.
// Holds the occupancy state machine type and its encodings.
package srl_fifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } fifo_state_e;

endpackage

// File: rtl/srl_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for srl_fifo_ctrl.
// The master modport is the side that pushes and pops; the slave modport is the FIFO.
interface srl_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_num_data_valid;
    logic                  err_ovf;
    logic                  err_unf;

    modport master (
        output if_write_ce, if_write, if_din, if_read_ce, if_read,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid, err_ovf, err_unf
    );

    modport slave (
        input  if_write_ce, if_write, if_din, if_read_ce, if_read,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid, err_ovf, err_unf
    );
endinterface

// File: rtl/srl_fifo_ctrl_shiftreg.sv
// Shift-register storage: newest entry at index 0, older entries move up on
// every write. The read port is a plain mux over the entries. No reset: the
// controller's occupancy count decides which entries are meaningful.
module srl_fifo_ctrl_shiftreg #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int SLOTS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [SLOTS];
    logic [DATA_WIDTH-1:0] mem_d [SLOTS];

    // Next storage contents: shift the first DEPTH slots on write, otherwise hold.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[0] = din;
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i+1] = mem_q[i];
            end
        end else begin
            mem_d[0] = mem_q[0];
        end
    end

    // Storage flops, intentionally without reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// Shift-register FIFO controller: occupancy count, EMPTY/PARTIAL/FULL state,
// registered status flags and sticky overflow/underflow error flags.
// Storage is delegated to srl_fifo_ctrl_shiftreg.
module srl_fifo_ctrl
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic           clk,
    input  logic           reset,
    srl_fifo_ctrl_if.slave fifo
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [CW-1:0]         count_q, count_d;
    fifo_state_e           state_q, state_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_unf_q, err_unf_d;

    // Accepted requests are gated by the registered flags, so full/empty never wrap.
    always_comb begin
        push_s = fifo.if_write & fifo.if_write_ce & full_n_q;
        pop_s  = fifo.if_read  & fifo.if_read_ce  & empty_n_q;
    end

    // Next occupancy, state, flags and sticky errors.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_s) state_d = ST_PARTIAL;
                else        state_d = ST_EMPTY;
            end
            ST_PARTIAL: begin
                if (push_s && !pop_s && (count_d == DEPTH_C))     state_d = ST_FULL;
                else if (pop_s && !push_s && (count_d == ZERO_C)) state_d = ST_EMPTY;
                else                                              state_d = ST_PARTIAL;
            end
            ST_FULL: begin
                if (pop_s) state_d = ST_PARTIAL;
                else       state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase

        empty_n_d = (count_d != ZERO_C);
        full_n_d  = (count_d != DEPTH_C);
        err_ovf_d = err_ovf_q | (fifo.if_write & fifo.if_write_ce & ~full_n_q);
        err_unf_d = err_unf_q | (fifo.if_read  & fifo.if_read_ce  & ~empty_n_q);
    end

    // Controller registers; reset empties the queue and clears the error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= ZERO_C;
            state_q   <= ST_EMPTY;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            state_q   <= state_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Head of queue is the oldest entry at count-1; when count is 2**ADDR_WIDTH the
    // low bits are zero and the subtraction wraps to the top slot, which is correct.
    always_comb begin
        if (count_q != ZERO_C) begin
            rd_addr_s = count_q[ADDR_WIDTH-1:0] - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rd_addr_s = {ADDR_WIDTH{1'b0}};
        end
    end

    srl_fifo_ctrl_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (push_s),
        .addr (rd_addr_s),
        .din  (fifo.if_din),
        .dout (fifo.if_dout)
    );

    assign fifo.if_full_n         = full_n_q;
    assign fifo.if_empty_n        = empty_n_q;
    assign fifo.if_num_data_valid = count_q;
    assign fifo.err_ovf           = err_ovf_q;
    assign fifo.err_unf           = err_unf_q;

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Scoreboard bench for srl_fifo_ctrl (DEPTH=2, DATA_WIDTH=8).
// The driver applies directed steps and queues hand-computed expectations;
// a monitor on the falling edge checks popped data and post-step status.
module tb_srl_fifo_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    bit   mon_en;

    typedef struct {
        int         idx;
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic       pv;     // a pop of pd is expected during this step
        logic [7:0] pd;
        logic [1:0] cnt;    // status after the step
        logic       fn;
        logic       en;
        logic       ovf;
        logic       unf;
        logic       dv;     // check dout after the step
        logic [7:0] dout;
    } step_t;

    step_t      exp_q[$];
    logic [7:0] pop_q[$];

    srl_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) fif ();

    srl_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (fif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic step_t mk(int idx, logic wr, logic [7:0] din, logic rd,
                                 logic pv, logic [7:0] pd, logic [1:0] cnt,
                                 logic fn, logic en, logic ovf, logic unf,
                                 logic dv, logic [7:0] dout);
        step_t s;
        s.idx = idx; s.wr = wr; s.din = din; s.rd = rd; s.pv = pv; s.pd = pd;
        s.cnt = cnt; s.fn = fn; s.en = en; s.ovf = ovf; s.unf = unf;
        s.dv = dv; s.dout = dout;
        return s;
    endfunction

    task automatic do_step(input step_t s);
        @(posedge clk);
        #2;
        fif.if_write   = s.wr;
        fif.if_din     = s.din;
        fif.if_read    = s.rd;
        exp_q.push_back(s);
        if (s.pv) pop_q.push_back(s.pd);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"},   32'(fif.if_num_data_valid), 32'd0);
        chk({tag, "_empty_n"}, 32'(fif.if_empty_n), 32'd0);
        chk({tag, "_full_n"},  32'(fif.if_full_n),  32'd1);
        chk({tag, "_ovf"},     32'(fif.err_ovf),    32'd0);
        chk({tag, "_unf"},     32'(fif.err_unf),    32'd0);
    endtask

    // Monitor: check the previous step's status, then any pop presented now.
    initial begin
        step_t pend;
        bit    have_pend;
        have_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                have_pend = 1'b0;
            end else begin
                if (have_pend) begin
                    chk($sformatf("step%0d_count", pend.idx), 32'(fif.if_num_data_valid), 32'(pend.cnt));
                    chk($sformatf("step%0d_full_n", pend.idx), 32'(fif.if_full_n), 32'(pend.fn));
                    chk($sformatf("step%0d_empty_n", pend.idx), 32'(fif.if_empty_n), 32'(pend.en));
                    chk($sformatf("step%0d_ovf", pend.idx), 32'(fif.err_ovf), 32'(pend.ovf));
                    chk($sformatf("step%0d_unf", pend.idx), 32'(fif.err_unf), 32'(pend.unf));
                    if (pend.dv) begin
                        chk($sformatf("step%0d_dout", pend.idx), 32'(fif.if_dout), 32'(pend.dout));
                    end
                end
                have_pend = 1'b0;
                if (exp_q.size() > 0) begin
                    pend      = exp_q.pop_front();
                    have_pend = 1'b1;
                end
                if (fif.if_read & fif.if_read_ce & fif.if_empty_n) begin
                    if (pop_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop: got %0h, want no pop", fif.if_dout);
                    end else begin
                        chk($sformatf("pop_data_t%0t", $time), 32'(fif.if_dout), 32'(pop_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        step_t vec[$];
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        reset  = 1'b1;
        fif.if_write_ce = 1'b1;
        fif.if_read_ce  = 1'b1;
        fif.if_write    = 1'b0;
        fif.if_read     = 1'b0;
        fif.if_din      = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("reset");
        reset  = 1'b0;
        mon_en = 1'b1;

        //          idx wr  din    rd  pv  pd     cnt   fn  en  ovf unf dv  dout
        vec.push_back(mk( 1, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1));
        vec.push_back(mk( 2, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        vec.push_back(mk( 3, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11));
        vec.push_back(mk( 4, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11));
        vec.push_back(mk( 5, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22));
        vec.push_back(mk( 6, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        vec.push_back(mk( 7, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11));
        vec.push_back(mk( 8, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11));
        vec.push_back(mk( 9, 1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22));
        vec.push_back(mk(10, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
        vec.push_back(mk(11, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44));
        vec.push_back(mk(12, 1'b1, 8'h55, 1'b1, 1'b1, 8'h44, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55));
        vec.push_back(mk(13, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55));
        vec.push_back(mk(14, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55));
        foreach (vec[i]) do_step(vec[i]);

        // Let the monitor finish the last step, then reset mid-cycle with two entries queued.
        @(negedge clk);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(posedge clk);
        #3;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Queue must behave as empty after release.
        vec.delete();
        vec.push_back(mk(15, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77));
        vec.push_back(mk(16, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        vec.push_back(mk(17, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        foreach (vec[i]) do_step(vec[i]);

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pops_drained", 32'(pop_q.size()), 32'd0);
        chk("steps_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/srl_fifo_ctrl.md
SRL_FIFO_CTRL -- requirements
Module: srl_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, token/data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 1, storage address width; DEPTH <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 2, entry count, legal range 2..2**ADDR_WIDTH.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 if_write_ce  input  1  write-side clock enable.
REQ-007 if_write  input  1  producer push request.
REQ-008 if_din  input  DATA_WIDTH  push data.
REQ-009 if_full_n  output  1  registered; 1 = space available.
REQ-010 if_read_ce  input  1  read-side clock enable.
REQ-011 if_read  input  1  consumer pop request.
REQ-012 if_dout  output  DATA_WIDTH  head-of-queue data.
REQ-013 if_empty_n  output  1  registered; 1 = data available.
REQ-014 if_num_data_valid  output  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
REQ-015 err_ovf  output  1  sticky overflow-attempt flag.
REQ-016 err_unf  output  1  sticky underflow-attempt flag.

Function
REQ-017 push SHALL be if_write & if_write_ce & if_full_n; pop SHALL be if_read & if_read_ce & if_empty_n.
REQ-018 Storage SHALL shift on push: entry 0 <= if_din, entry i+1 <= entry i; no shift otherwise.
REQ-019 Occupancy count SHALL update: push only +1, pop only -1, both or neither unchanged.
REQ-020 Read address SHALL be count-1 when count > 0, else 0; if_dout = storage[read address], combinational from storage.
REQ-021 Data pushed in cycle N SHALL be poppable and present on if_dout from cycle N+1 (1-cycle fall-through latency).
REQ-022 FSM states EMPTY, PARTIAL, FULL: EMPTY->PARTIAL on push; PARTIAL->FULL on push-only reaching DEPTH; PARTIAL->EMPTY on pop-only reaching 0; FULL->PARTIAL on pop; push+pop holds state.
REQ-023 if_empty_n, if_full_n, if_num_data_valid SHALL be registered from next-state count (no combinational path from if_write/if_read).
REQ-024 At FULL, simultaneous push and pop SHALL perform pop only (if_full_n=0 gates push).
REQ-025 At EMPTY, simultaneous push and pop SHALL perform push only.
REQ-026 err_ovf SHALL set when if_write & if_write_ce & !if_full_n; err_unf when if_read & if_read_ce & !if_empty_n; both clear only on reset.
REQ-027 Rejected requests SHALL not alter storage, count or state.
REQ-028 Count SHALL never wrap: never exceeds DEPTH nor goes below 0.

Reset
REQ-029 reset assertion SHALL immediately force: state EMPTY, count 0, if_empty_n 0, if_full_n 1, if_num_data_valid 0, err_ovf 0, err_unf 0.
REQ-030 Storage contents SHALL not be reset; if_dout undefined while empty.
REQ-031 reset mid-operation SHALL discard all queued entries; first push after release treated as into empty queue.

Structure
REQ-032 FSM state typedef and state encodings SHALL live in shared package srl_fifo_pkg.
REQ-033 Storage SHALL be one sub-module srl_fifo_ctrl_shiftreg (DATA_WIDTH/ADDR_WIDTH/DEPTH, ports clk, we, addr, din, dout), we = push, no reset.
REQ-034 Controller (count, FSM, flags, errors) SHALL be in srl_fifo_ctrl itself.

Verification (DEPTH=2, DATA_WIDTH=8)
REQ-035 Reset, push 0xA1 -> next cycle if_empty_n=1, if_dout=0xA1, if_num_data_valid=1, if_full_n=1.
REQ-036 Push 0x11, 0x22 back-to-back -> if_full_n=0, count 2; pops yield 0x11 then 0x22, then if_empty_n=0.
REQ-037 Full, push 0x33 + pop same cycle -> 0x11 popped, 0x33 dropped, err_ovf=1, count 1, if_full_n=1.
REQ-038 Empty, push 0x44 + pop same cycle -> pop ignored, err_unf=1, count 1, if_dout=0x44.
REQ-039 One entry queued, push 0x55 + pop -> 0x44 out, count stays 1, if_dout=0x55 next cycle.
REQ-040 Reset asserted mid-cycle with 2 entries -> outputs return to reset values before next clk edge; err flags cleared.
